// File: rtl/ipid_frame_collector.sv
// ============================================================================
// ipid_frame_collector: requests, checks and commits framed IP IDs over GPIO.
// Rev 1.0
// ============================================================================
`default_nettype none

module ipid_frame_collector #(
    parameter int                WORD_W       = 16,
    parameter int                WORDS_PER_ID = 16,
    parameter int                NUM_IPS      = 16,
    parameter logic [WORD_W-1:0] HDR_WORD     = WORD_W'(16'h7A7A),
    parameter logic [WORD_W-1:0] TRL_WORD     = WORD_W'(16'hB9B9),
    parameter int                TIMEOUT_CYC  = 1024,
    parameter int                MAX_RETRY    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             trigger_out,
    output logic [$clog2(NUM_IPS)-1:0]       ip_addr_out,
    input  logic                             valid_in,
    input  logic [WORD_W-1:0]                data_in,
    output logic                             id_wr_en,
    output logic [$clog2(NUM_IPS)-1:0]       id_wr_addr,
    output logic [WORD_W*WORDS_PER_ID-1:0]   id_wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [$clog2(NUM_IPS)-1:0]       err_ip
);

    localparam int IDX_W = $clog2(NUM_IPS);
    localparam int CNT_W = (WORDS_PER_ID > 1) ? $clog2(WORDS_PER_ID) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int ID_W  = WORD_W * WORDS_PER_ID;

    localparam logic [IDX_W-1:0] LAST_IP   = IDX_W'(NUM_IPS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ID - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYC);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_DATA, S_TRL, S_COMMIT, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              redo_q, redo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ID_W-1:0]   buf_q, buf_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [IDX_W-1:0]  err_ip_q, err_ip_d;
    logic              fail;
    logic [1:0]        fail_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            redo_q     <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            buf_q      <= '0;
            err_code_q <= 2'd0;
            err_ip_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            redo_q     <= redo_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            buf_q      <= buf_d;
            err_code_q <= err_code_d;
            err_ip_q   <= err_ip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        redo_d     = redo_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        buf_d      = buf_q;
        err_code_d = err_code_q;
        err_ip_d   = err_ip_q;
        fail       = 1'b0;
        fail_code  = 2'd0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_REQ;
                    idx_d      = '0;
                    retry_d    = '0;
                    redo_d     = 1'b0;
                    tmo_d      = '0;
                    err_code_d = 2'd0;
                    err_ip_d   = '0;
                end
            end
            S_REQ: begin
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
                if (valid_in) begin
                    if (data_in == HDR_WORD) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'd0;
                    end
                end else if (tmo_d == TMO_MAX) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end
            end
            S_DATA: begin
                if (valid_in) begin
                    buf_d[cnt_q*WORD_W +: WORD_W] = data_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_TRL;
                    end
                end else begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            S_TRL: begin
                if (!valid_in) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end else if (data_in == TRL_WORD) begin
                    state_d = S_COMMIT;
                end else begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end
            end
            S_COMMIT: begin
                state_d = S_GAP;
                redo_d  = 1'b0;
            end
            S_GAP: begin
                // Holding here until valid drops also swallows any tail of a rejected frame.
                if (!valid_in) begin
                    if (redo_q) begin
                        state_d = S_REQ;
                        redo_d  = 1'b0;
                        tmo_d   = '0;
                    end else if (idx_q == LAST_IP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        idx_d   = idx_q + IDX_W'(1);
                        retry_d = '0;
                        tmo_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            if (retry_q < RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                redo_d  = 1'b1;
                state_d = S_GAP;
            end else begin
                state_d    = S_ERR;
                err_code_d = fail_code;
                err_ip_d   = idx_q;
            end
        end
    end

    assign trigger_out = (state_q == S_REQ) || (state_q == S_DATA) || (state_q == S_TRL);
    assign ip_addr_out = idx_q;
    assign id_wr_en    = (state_q == S_COMMIT);
    assign id_wr_addr  = idx_q;
    assign id_wr_data  = buf_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign err_code    = err_code_q;
    assign err_ip      = err_ip_q;

endmodule

`default_nettype wire

// File: tb/tb_ipid_frame_collector.sv
// ============================================================================
// tb_ipid_frame_collector: scoreboard bench for the framed IP ID collector.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ipid_frame_collector;

    localparam logic [15:0] HDR = 16'h7A7A;
    localparam logic [15:0] TRL = 16'hB9B9;

    typedef struct {
        int           addr;
        logic [255:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    // default-parameter instance
    logic         a_start = 1'b0, a_valid = 1'b0;
    logic [15:0]  a_data = '0;
    logic         a_trig, a_wr_en, a_busy, a_done, a_error;
    logic [3:0]   a_ip_addr, a_wr_addr, a_err_ip;
    logic [255:0] a_wr_data;
    logic [1:0]   a_err_code;

    ipid_frame_collector u_dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .trigger_out(a_trig), .ip_addr_out(a_ip_addr),
        .valid_in(a_valid), .data_in(a_data),
        .id_wr_en(a_wr_en), .id_wr_addr(a_wr_addr), .id_wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .error(a_error),
        .err_code(a_err_code), .err_ip(a_err_ip)
    );

    // wide-word, short-run instance
    logic         b_start = 1'b0, b_valid = 1'b0;
    logic [31:0]  b_data = '0;
    logic         b_trig, b_wr_en, b_busy, b_done, b_error;
    logic [1:0]   b_ip_addr, b_wr_addr, b_err_ip;
    logic [255:0] b_wr_data;
    logic [1:0]   b_err_code;

    ipid_frame_collector #(
        .WORD_W(32), .WORDS_PER_ID(8), .NUM_IPS(4),
        .HDR_WORD(32'h0000_7A7A), .TRL_WORD(32'h0000_B9B9)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .trigger_out(b_trig), .ip_addr_out(b_ip_addr),
        .valid_in(b_valid), .data_in(b_data),
        .id_wr_en(b_wr_en), .id_wr_addr(b_wr_addr), .id_wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .error(b_error),
        .err_code(b_err_code), .err_ip(b_err_ip)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_pl();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // commit monitors: every strobe must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (!rst && a_wr_en) begin
            if (exp_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_commit_a: got addr %0d, expected no commit", a_wr_addr);
            end else begin
                ea = exp_a.pop_front();
                check("commit_addr_a", 256'(a_wr_addr), 256'(ea.addr));
                check("commit_data_a", a_wr_data, ea.data);
            end
        end
        if (!rst && b_wr_en) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_commit_b: got addr %0d, expected no commit", b_wr_addr);
            end else begin
                eb = exp_b.pop_front();
                check("commit_addr_b", 256'(b_wr_addr), 256'(eb.addr));
                check("commit_data_b", b_wr_data, eb.data);
            end
        end
    end

    task automatic wait_trig_a();
        int n = 0;
        while (a_trig !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("trigger_rise_a", 256'(a_trig), 256'(1));
    endtask

    task automatic start_a();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    // nw < 16 truncates the frame after nw payload words (no trailer)
    task automatic send_a(input int ip, input logic [15:0] hdr, input logic [15:0] trl,
                          input int nw, input logic [255:0] pl, input bit commit);
        exp_t e;
        wait_trig_a();
        check("trigger_ip_addr_a", 256'(a_ip_addr), 256'(ip));
        if (commit) begin e.addr = ip; e.data = pl; exp_a.push_back(e); end
        a_valid = 1'b1; a_data = hdr;
        for (int w = 0; w < nw; w++) begin @(negedge clk); a_data = pl[w*16 +: 16]; end
        if (nw == 16) begin @(negedge clk); a_data = trl; end
        @(negedge clk); a_valid = 1'b0; a_data = '0;
        if (nw == 16) check("trigger_low_after_frame_a", 256'(a_trig), '0);
    endtask

    task automatic wait_end_a(input int budget);
        int n = 0;
        while (!(a_done || a_error) && n < budget) begin @(negedge clk); n++; end
    endtask

    task automatic check_end_a(input string tag, input bit exp_done, input bit exp_err,
                               input logic [1:0] code, input logic [3:0] ip);
        check({tag, "_done"},  256'(a_done),  256'(exp_done));
        check({tag, "_error"}, 256'(a_error), 256'(exp_err));
        check({tag, "_busy"},  256'(a_busy),  '0);
        if (exp_err) begin
            check({tag, "_err_code"}, 256'(a_err_code), 256'(code));
            check({tag, "_err_ip"},   256'(a_err_ip),   256'(ip));
        end
        check({tag, "_commits_outstanding"}, 256'(exp_a.size()), '0);
    endtask

    task automatic run_clean_a(input int bad_hdr_ip);
        start_a();
        for (int ip = 0; ip < 16; ip++) begin
            if (ip == bad_hdr_ip) send_a(ip, 16'h7A7B, TRL, 16, rand_pl(), 1'b0);
            send_a(ip, HDR, TRL, 16, rand_pl(), 1'b1);
        end
        wait_end_a(100);
    endtask

    task automatic send_b(input int ip, input logic [255:0] pl);
        exp_t e;
        int n = 0;
        while (b_trig !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("trigger_rise_b", 256'(b_trig), 256'(1));
        check("trigger_ip_addr_b", 256'(b_ip_addr), 256'(ip));
        e.addr = ip; e.data = pl; exp_b.push_back(e);
        b_valid = 1'b1; b_data = 32'h0000_7A7A;
        for (int w = 0; w < 8; w++) begin @(negedge clk); b_data = pl[w*32 +: 32]; end
        @(negedge clk); b_data = 32'h0000_B9B9;
        @(negedge clk); b_valid = 1'b0; b_data = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #3;
        check("reset_ctrl_a", 256'({a_trig, a_ip_addr, a_wr_en, a_wr_addr, a_busy, a_done,
                                    a_error, a_err_code, a_err_ip}), '0);
        check("reset_data_a", a_wr_data, '0);
        @(negedge clk); rst = 1'b0;

        // 16 clean frames
        run_clean_a(-1);
        check_end_a("clean_run", 1'b1, 1'b0, 2'd0, 4'd0);

        // bad header on IP 3, resent clean
        run_clean_a(3);
        check_end_a("bad_hdr_retry", 1'b1, 1'b0, 2'd0, 4'd0);

        // IP 5 bad trailer three times exhausts retries
        start_a();
        for (int ip = 0; ip < 5; ip++) send_a(ip, HDR, TRL, 16, rand_pl(), 1'b1);
        for (int k = 0; k < 3; k++) send_a(5, HDR, 16'hB9B8, 16, rand_pl(), 1'b0);
        wait_end_a(100);
        check_end_a("bad_trailer", 1'b0, 1'b1, 2'd2, 4'd5);

        // short frame on IP 0, then silence until timeouts exhaust retries
        start_a();
        send_a(0, HDR, TRL, 8, rand_pl(), 1'b0);
        wait_end_a(3 * (1024 + 5));
        check_end_a("short_then_timeout", 1'b0, 1'b1, 2'd3, 4'd0);

        // reset while IP 2 is mid-payload, then a full restart
        start_a();
        send_a(0, HDR, TRL, 16, rand_pl(), 1'b1);
        send_a(1, HDR, TRL, 16, rand_pl(), 1'b1);
        wait_trig_a();
        a_valid = 1'b1; a_data = HDR;
        for (int w = 0; w < 4; w++) begin @(negedge clk); a_data = 16'h1111 * 16'(w + 1); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_ctrl_a", 256'({a_trig, a_ip_addr, a_wr_en, a_wr_addr, a_busy,
                                           a_done, a_error, a_err_code, a_err_ip}), '0);
        check("midrun_reset_data_a", a_wr_data, '0);
        a_valid = 1'b0; a_data = '0;
        @(negedge clk); rst = 1'b0;
        check("post_reset_outstanding", 256'(exp_a.size()), '0);
        run_clean_a(-1);
        check_end_a("restart_run", 1'b1, 1'b0, 2'd0, 4'd0);

        // wide words: 4 IDs of 8 x 32 bits
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int ip = 0; ip < 4; ip++) send_b(ip, rand_pl());
        n = 0;
        while (!(b_done || b_error) && n < 100) begin @(negedge clk); n++; end
        check("wide_done",  256'(b_done),  256'(1));
        check("wide_error", 256'(b_error), '0);
        check("wide_commits_outstanding", 256'(exp_b.size()), '0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
